vga_mode_sched: RTL and testbench

VGA_MODE_SCHED -- requirements
Module: vga_mode_sched

---
 rtl/vga_mode_sched.sv | 114 +++++++++++
 tb/tb_vga_mode_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_sched.sv
// Video mode scheduler: holds the pattern mode and changes it only at the start of
// vertical blanking, either by auto-cycling every FRAMES_PER_MODE frames or on a host request.
module vga_mode_sched #(
  parameter int NUM_MODES       = 8,
  parameter int FRAMES_PER_MODE = 60,
  parameter int V_ACTIVE        = 480,
  parameter int H_ACTIVE        = 640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] Xpos,
  input  logic [11:0] Ypos,
  input  logic        Disp_activ,
  input  logic        auto_en,
  input  logic        host_req,
  input  logic [3:0]  host_mode,
  output logic [3:0]  mode,
  output logic        host_ack,
  output logic        host_err,
  output logic        busy,
  output logic        mode_chg,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, PEND, RELEASE} state_t;

  state_t     state;
  logic [3:0] req_reg;
  logic       vblank;
  logic       vblank_d;
  logic       vs_pulse;
  logic       req_legal;
  logic       auto_wrap;
  logic [3:0] next_mode;

  assign vblank    = (Ypos >= 12'(V_ACTIVE));
  assign vs_pulse  = vblank & ~vblank_d;
  assign req_legal = ({1'b0, req_reg} < 5'(NUM_MODES));
  assign auto_wrap = (frame_cnt == 8'(FRAMES_PER_MODE - 1));
  assign next_mode = (mode == 4'(NUM_MODES - 1)) ? 4'd0 : mode + 4'd1;

  // NOTE: all state and outputs update with <= so every branch sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_reg   <= 4'd0;
      vblank_d  <= 1'b1;
      mode      <= 4'd0;
      host_ack  <= 1'b0;
      host_err  <= 1'b0;
      busy      <= 1'b0;
      mode_chg  <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      vblank_d <= vblank;
      host_ack <= 1'b0;
      host_err <= 1'b0;
      mode_chg <= 1'b0;

      case (state)
        IDLE: begin
          if (host_req) begin
            // A request taken on a vs_pulse waits for the next one; the auto step is dropped.
            req_reg <= host_mode;
            state   <= PEND;
            busy    <= 1'b1;
            if (vs_pulse) frame_cnt <= 8'd0;
          end else if (!auto_en) begin
            frame_cnt <= 8'd0;
          end else if (vs_pulse) begin
            if (auto_wrap) begin
              frame_cnt <= 8'd0;
              mode      <= next_mode;
              mode_chg  <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        PEND: begin
          if (vs_pulse) begin
            host_ack  <= 1'b1;
            frame_cnt <= 8'd0;
            state     <= RELEASE;
            if (req_legal) begin
              mode     <= req_reg;
              mode_chg <= (req_reg != mode);
            end else begin
              host_err <= 1'b1;
            end
          end else if (!auto_en) begin
            frame_cnt <= 8'd0;
          end
        end

        RELEASE: begin
          if (!host_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          if (!auto_en) frame_cnt <= 8'd0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Visible pixels outside the active window mean the sync generator is misconfigured.
  a_disp_in_window: assert property (@(posedge clk) disable iff (rst)
    Disp_activ |-> ((Ypos < 12'(V_ACTIVE)) && (Xpos < 12'(H_ACTIVE))));

endmodule

// File: tb/tb_vga_mode_sched.sv
// Bench for vga_mode_sched: directed table of host loads, corner sequences, and random
// traffic compared every cycle against a frame-level reference model.
module tb_vga_mode_sched;

  localparam int NUM_MODES       = 4;
  localparam int FRAMES_PER_MODE = 3;
  localparam int V_ACTIVE        = 4;
  localparam int H_ACTIVE        = 8;
  localparam int H_TOTAL         = 10;
  localparam int V_TOTAL         = 6;
  localparam int FRAME_CYC       = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] Xpos = '0;
  logic [11:0] Ypos = '0;
  logic        Disp_activ = 1'b0;
  logic        auto_en = 1'b0;
  logic        host_req = 1'b0;
  logic [3:0]  host_mode = '0;
  logic [3:0]  mode;
  logic        host_ack;
  logic        host_err;
  logic        busy;
  logic        mode_chg;
  logic [7:0]  frame_cnt;

  vga_mode_sched #(
    .NUM_MODES(NUM_MODES), .FRAMES_PER_MODE(FRAMES_PER_MODE),
    .V_ACTIVE(V_ACTIVE), .H_ACTIVE(H_ACTIVE)
  ) dut (
    .clk(clk), .rst(rst), .Xpos(Xpos), .Ypos(Ypos), .Disp_activ(Disp_activ),
    .auto_en(auto_en), .host_req(host_req), .host_mode(host_mode),
    .mode(mode), .host_ack(host_ack), .host_err(host_err), .busy(busy),
    .mode_chg(mode_chg), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a request queue, a release flag and a frame counter advanced per frame.
  int  req_q[$];
  bit  m_release = 0;
  bit  m_prev_vb = 1;
  int  m_mode = 0, m_cnt = 0;
  bit  m_ack = 0, m_err = 0, m_chg = 0, m_busy = 0;

  task automatic model_step();
    bit vb, vs;
    int v;
    vb = (int'(Ypos) >= V_ACTIVE);
    vs = vb && !m_prev_vb;
    m_ack = 0; m_err = 0; m_chg = 0;
    if (rst) begin
      req_q.delete();
      m_release = 0; m_prev_vb = 1; m_mode = 0; m_cnt = 0; m_busy = 0;
      return;
    end
    m_prev_vb = vb;
    if (req_q.size() != 0) begin
      if (vs) begin
        v = req_q.pop_front();
        m_ack = 1; m_cnt = 0; m_release = 1;
        if (v < NUM_MODES) begin m_chg = (v != m_mode); m_mode = v; end
        else m_err = 1;
      end else if (!auto_en) m_cnt = 0;
    end else if (m_release) begin
      if (!host_req) m_release = 0;
      if (!auto_en) m_cnt = 0;
    end else if (host_req) begin
      req_q.push_back(int'(host_mode));
      if (vs) m_cnt = 0;
    end else if (!auto_en) begin
      m_cnt = 0;
    end else if (vs) begin
      m_cnt++;
      if (m_cnt == FRAMES_PER_MODE) begin
        m_cnt = 0; m_mode = (m_mode + 1) % NUM_MODES; m_chg = 1;
      end
    end
    m_busy = (req_q.size() != 0) || m_release;
  endtask

  // Sync timing generated by the bench; one call = one clock cycle.
  int hx = 0, vy = 0, last_x = 0, last_y = 0, vs_seen = 0;

  task automatic cycle();
    Xpos = 12'(hx);
    Ypos = 12'(vy);
    Disp_activ = (hx < H_ACTIVE) && (vy < V_ACTIVE);
    if (!rst && vy == V_ACTIVE && hx == 0) vs_seen++;
    model_step();
    @(posedge clk);
    #1;
    check("mode", int'(mode), m_mode);
    check("host_ack", int'(host_ack), int'(m_ack));
    check("host_err", int'(host_err), int'(m_err));
    check("busy", int'(busy), int'(m_busy));
    check("mode_chg", int'(mode_chg), int'(m_chg));
    check("frame_cnt", int'(frame_cnt), m_cnt);
    last_x = hx; last_y = vy;
    hx++;
    if (hx == H_TOTAL) begin hx = 0; vy = (vy + 1) % V_TOTAL; end
  endtask

  task automatic do_reset();
    rst = 1'b1; host_req = 1'b0;
    cycle(); cycle();
    check("rst_mode", int'(mode), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ack", int'(host_ack), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    rst = 1'b0;
    hx = 0; vy = 0;
  endtask

  task automatic wait_pos(input int x, input int y);
    for (int i = 0; i < 2 * FRAME_CYC && !(hx == x && vy == y); i++) cycle();
  endtask

  task automatic wait_ack(output bit got);
    got = 0;
    for (int i = 0; i < 2 * FRAME_CYC && !got; i++) begin
      cycle();
      got = host_ack;
    end
    if (!got) check("ack_timeout", 0, 1);
  endtask

  typedef struct {
    logic [3:0] code;
    int         exp_mode;
    bit         exp_err;
    bit         exp_chg;
  } host_vec_t;

  host_vec_t vecs[8];

  initial begin
    bit got;
    int acks, busy_low, cur_mode;
    int chg_modes[$];
    int chg_vs[$];

    #500000;
    $display("FAIL watchdog: got 0 expected 1 (simulation did not finish)");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int acks, busy_low, cur_mode;
    int chg_modes[$];
    int chg_vs[$];

    vecs[0] = '{4'd2,  2, 1'b0, 1'b1};
    vecs[1] = '{4'd2,  2, 1'b0, 1'b0};
    vecs[2] = '{4'd9,  2, 1'b1, 1'b0};
    vecs[3] = '{4'd0,  0, 1'b0, 1'b1};
    vecs[4] = '{4'd3,  3, 1'b0, 1'b1};
    vecs[5] = '{4'd4,  3, 1'b1, 1'b0};
    vecs[6] = '{4'd15, 3, 1'b1, 1'b0};
    vecs[7] = '{4'd1,  1, 1'b0, 1'b1};

    // Auto wrap over 12 frames.
    do_reset();
    auto_en = 1'b1;
    vs_seen = 0;
    for (int i = 0; i < 12 * FRAME_CYC; i++) begin
      cycle();
      if (mode_chg) begin chg_modes.push_back(int'(mode)); chg_vs.push_back(vs_seen); end
    end
    check("wrap_num_changes", chg_modes.size(), 4);
    for (int k = 0; k < chg_modes.size() && k < 4; k++) begin
      check("wrap_mode_seq", chg_modes[k], (k + 1) % NUM_MODES);
      check("wrap_change_frame", chg_vs[k], (k + 1) * FRAMES_PER_MODE);
    end
    check("wrap_final_mode", int'(mode), 0);

    // Host loads, including same-mode and illegal codes.
    do_reset();
    auto_en = 1'b0;
    cur_mode = 0;
    for (int i = 0; i < 8; i++) begin
      wait_pos(3, 1);
      host_req = 1'b1; host_mode = vecs[i].code;
      cycle();
      check("load_busy", int'(busy), 1);
      check("load_mode_held", int'(mode), cur_mode);
      host_mode = ~vecs[i].code;
      wait_ack(got);
      check("load_ack_after_vs", last_y * H_TOTAL + last_x, V_ACTIVE * H_TOTAL);
      check("load_mode", int'(mode), vecs[i].exp_mode);
      check("load_err", int'(host_err), int'(vecs[i].exp_err));
      check("load_chg", int'(mode_chg), int'(vecs[i].exp_chg));
      host_req = 1'b0;
      cycle();
      check("load_ack_one_cycle", int'(host_ack), 0);
      check("load_busy_cleared", int'(busy), 0);
      cur_mode = vecs[i].exp_mode;
    end

    // Collision: auto frame_cnt=2 while a host request is pending.
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 3 * FRAME_CYC && frame_cnt != 8'd2; i++) cycle();
    check("coll_cnt_reached", int'(frame_cnt), 2);
    wait_pos(3, 1);
    host_req = 1'b1; host_mode = 4'd3;
    cycle();
    wait_ack(got);
    check("coll_mode", int'(mode), 3);
    check("coll_frame_cnt", int'(frame_cnt), 0);
    check("coll_chg", int'(mode_chg), 1);
    host_req = 1'b0;
    for (int i = 0; i < FRAME_CYC; i++) cycle();
    check("coll_post_cnt", int'(frame_cnt), 1);
    check("coll_post_mode", int'(mode), 3);

    // Handshake: request held 3 frames past the ack.
    do_reset();
    auto_en = 1'b0;
    wait_pos(3, 1);
    host_req = 1'b1; host_mode = 4'd1;
    acks = 0; busy_low = 0;
    cycle();
    wait_ack(got);
    if (got) acks++;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      cycle();
      if (host_ack) acks++;
      if (!busy) busy_low++;
    end
    check("hs_single_ack", acks, 1);
    check("hs_busy_held", busy_low, 0);
    host_req = 1'b0;
    cycle();
    check("hs_busy_drop", int'(busy), 0);

    // Reset mid-PEND, released in blanking with host_req still high.
    do_reset();
    auto_en = 1'b0;
    wait_pos(3, 1);
    host_req = 1'b1; host_mode = 4'd2;
    cycle();
    check("rp_busy", int'(busy), 1);
    wait_pos(9, 3);
    rst = 1'b1;
    cycle(); cycle(); cycle();
    check("rp_mode", int'(mode), 0);
    check("rp_busy_rst", int'(busy), 0);
    check("rp_ack_rst", int'(host_ack), 0);
    check("rp_err_rst", int'(host_err), 0);
    check("rp_chg_rst", int'(mode_chg), 0);
    rst = 1'b0;
    cycle();
    check("rp_reaccept", int'(busy), 1);
    acks = 0;
    for (int i = 0; i < FRAME_CYC && !(hx == 0 && vy == 0); i++) begin
      cycle();
      if (host_ack) acks++;
    end
    check("rp_no_ack_in_blank", acks, 0);
    wait_ack(got);
    check("rp_mode_applied", int'(mode), 2);
    host_req = 1'b0;
    cycle();

    // Reset released inside blanking must not count a frame.
    auto_en = 1'b1;
    wait_pos(5, 4);
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < FRAME_CYC && !(hx == 0 && vy == 0); i++) cycle();
    check("rb_no_spurious_vs", int'(frame_cnt), 0);
    wait_pos(1, 4);
    check("rb_first_frame", int'(frame_cnt), 1);

    // Random traffic against the model.
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      if (!host_req) host_req = ($urandom_range(0, 99) == 0);
      else host_req = ($urandom_range(0, 29) != 0);
      host_mode = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 1499) == 0);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
